vga_scanout: RTL
================

// Module: vga_scanout
// PURPOSE
//  Display-side consumer of the 640x480x3b frame_cell RAM. Generates 640x480@60
//  VGA timing, drives frame_cell read address (read_frame_width/height), realigns
//  returned read_data with delayed sync/blank, and emits registered hsync/vsync/RGB.
//  Also exports vblank/frame_start so the upstream writer can schedule updates.
// PARAMETERS
//  H_ACTIVE 640 visible px/line;  H_FP 16;  H_SYNC 96;  H_BP 48   (line = 800 clk)
//  V_ACTIVE 480 visible lines;    V_FP 10;  V_SYNC 2;   V_BP 33   (frame = 525 lines)
//  RD_LATENCY 1  clk cycles from read address to valid read_data (legal 1..4)
// PORTS
//  clk                input   1   pixel clock (25.175 MHz); all state on rising edge
//  rst_n              input   1   asynchronous reset, active-low
//  read_frame_width   output  10  column address to frame_cell
//  read_frame_height  output  9   row address to frame_cell
//  read_data          input   3   pixel from frame_cell, valid RD_LATENCY clk after address
//  vga_hsync          output  1   horizontal sync, active-low
//  vga_vsync          output  1   vertical sync, active-low
//  vga_rgb            output  3   {R,G,B} = read_data bits {2,1,0}; 0 during blanking
//  vblank             output  1   high while v_count >= V_ACTIVE (counter timing)
//  frame_start        output  1   1-clk pulse when counters at (0,0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): h_count=0, v_count=0, delay pipe cleared; vga_hsync=1,
//    vga_vsync=1, vga_rgb=0, frame_start=0, vblank=0, read address = 0.
//    Mid-frame reset: outputs go to reset values immediately; scan restarts at (0,0)
//    on the first clk after rst_n deasserts; no partial line is completed.
//  - h_count 0..799 increments every clk; at 799 wraps to 0 and v_count increments;
//    v_count 0..524 wraps to 0 when (h=799, v=524). No other wrap points.
//  - active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
//  - read_frame_width = active ? h_count : 0; read_frame_height = active ? v_count : 0
//    (combinational from counters; bit widths truncate exactly, no overflow possible).
//  - hsync_raw low for h_count in [656,751]; vsync_raw low for v_count in [490,491].
//  - active/hsync_raw/vsync_raw pass through a RD_LATENCY-stage shift register, then
//    one output register together with read_data: vga_* reflect counter position
//    (h,v) exactly RD_LATENCY+1 clk after counters held (h,v).
//  - vga_rgb = delayed_active ? read_data : 3'b000.
//  - frame_start registered: high the clk after counters read (0,0), one cycle only.
//  - vblank registered from v_count, 1 clk after counter; high lines 480..524.
//  - No handshake with frame_cell: read address is issued every clk unconditionally;
//    writer must not rely on scanout stalling.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: adds input test_pattern (1b). When test_pattern=1,
//   pixel source = (h_count + v_count) mod 8 taken at counter stage and delayed
//   RD_LATENCY stages, replacing read_data; sync/blank unchanged; test_pattern is
//   sampled per pixel (may change mid-line).
//  Not defined: no test_pattern port; pixel source is always read_data.
// TESTING
//  1 Reset: rst_n=0 for 3 clk -> hsync=1, vsync=1, rgb=0, addr=(0,0), frame_start=0.
//  2 Line timing: count clk between hsync falling edges = 800; low width = 96; first
//    low at h=656 i.e. 656+RD_LATENCY+1 clk after frame_start's counter cycle.
//  3 Frame timing: vsync low for 2 lines (1600 clk), period 525*800 = 420000 clk;
//    frame_start pulses exactly once per 420000 clk.
//  4 Data alignment: model frame_cell loaded with (w+h) mod 8, RD_LATENCY=1 and 3 ->
//    every active output pixel equals (h+v) mod 8; all blanking pixels = 0.
//  5 Boundaries: at (639,479) addr=(639,479); at (640,479) addr=(0,0), rgb goes 0
//    RD_LATENCY+1 clk later; at (799,524)->(0,0) vblank falls, frame_start pulses.
//  6 Mid-frame reset at (300,200): outputs reset same cycle; after release first
//    frame_start occurs 1 clk later and next hsync low at h=656 of line 0.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator that scans the frame_cell RAM out to hsync/vsync/RGB.
// Define VGA_TEST_PATTERN_EN to add a test_pattern input that substitutes a (h+v) mod 8 diagonal pattern.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  output logic [9:0] read_frame_width,
  output logic [8:0] read_frame_height,
  input  logic [2:0] read_data,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_rgb,
  output logic       vblank,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;
  logic [2:0] pix_src;

  logic [RD_LATENCY-1:0] act_pipe;
  logic [RD_LATENCY-1:0] hs_pipe;
  logic [RD_LATENCY-1:0] vs_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  // Address is issued every cycle; outside the visible area it parks at (0,0).
  always_comb begin
    active            = (h_count < H_VIS) && (v_count < V_VIS);
    hsync_raw         = !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
    vsync_raw         = !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
    read_frame_width  = active ? h_count : '0;
    read_frame_height = active ? v_count[8:0] : '0;
  end

  // Control delay matches the RAM read latency so sync/blank line up with read_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      act_pipe[0] <= active;
      hs_pipe[0]  <= hsync_raw;
      vs_pipe[0]  <= vsync_raw;
      for (int i = 1; i < RD_LATENCY; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]            pattern;
  logic [2:0]            pat_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] tp_pipe;

  assign pattern = h_count[2:0] + v_count[2:0];

  // test_pattern is captured per pixel alongside the address so it can toggle mid-line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pat_pipe[i] <= '0;
    end else begin
      tp_pipe[0]  <= test_pattern;
      pat_pipe[0] <= pattern;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tp_pipe[i]  <= tp_pipe[i-1];
        pat_pipe[i] <= pat_pipe[i-1];
      end
    end
  end

  assign pix_src = tp_pipe[RD_LATENCY-1] ? pat_pipe[RD_LATENCY-1] : read_data;
`else
  assign pix_src = read_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      vga_hsync   <= hs_pipe[RD_LATENCY-1];
      vga_vsync   <= vs_pipe[RD_LATENCY-1];
      vga_rgb     <= act_pipe[RD_LATENCY-1] ? pix_src : 3'b000;
      frame_start <= (h_count == '0) && (v_count == '0);
      vblank      <= (v_count >= V_VIS);
    end
  end

endmodule
